// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone arbiter sharing the IO-bus master port between several masters,
// with a watchdog that aborts transfers a slave never terminates.
module wb_io_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
  output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o,
  output logic [31:0]               timeout_adr_o
);

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {StIdle, StGrant, StAbort, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            tadr_q, tadr_d;

  logic [31:0] m_adr [NUM_MASTERS];
  logic [31:0] m_dat [NUM_MASTERS];
  logic [3:0]  m_sel [NUM_MASTERS];
  logic [2:0]  m_cti [NUM_MASTERS];
  logic [1:0]  m_bte [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign m_adr[i] = wbm_adr_i[32*i +: 32];
    assign m_dat[i] = wbm_dat_i[32*i +: 32];
    assign m_sel[i] = wbm_sel_i[4*i +: 4];
    assign m_cti[i] = wbm_cti_i[3*i +: 3];
    assign m_bte[i] = wbm_bte_i[2*i +: 2];
  end

  // last_q doubles as the index of the current owner while a grant is held.
  logic sel_cyc, sel_stb, resp, expire;
  assign sel_cyc = wbm_cyc_i[last_q];
  assign sel_stb = wbm_stb_i[last_q];
  assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign expire  = (TIMEOUT_CYCLES != 0) && (state_q == StGrant) && sel_cyc && sel_stb &&
                   !resp && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
  logic            hi_found, lo_found;
  logic [IdxW-1:0] hi_idx, lo_idx, win_idx;
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (wbm_cyc_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(i);
        if (IdxW'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = IdxW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tadr_d  = tadr_q;
    cnt_d   = '0;
    case (state_q)
      StIdle: begin
        if (lo_found) begin
          state_d = StGrant;
          last_d  = win_idx;
          grant_d = NUM_MASTERS'(1) << win_idx;
        end
      end
      StGrant: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (expire) begin
          state_d = StAbort;
          tadr_d  = m_adr[last_q];
        end else if ((TIMEOUT_CYCLES != 0) && sel_stb && !resp && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StAbort: state_d = StDrain;
      StDrain: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      tadr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tadr_q  <= tadr_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    case (state_q)
      StGrant: begin
        wbs_adr_o = m_adr[last_q];
        wbs_dat_o = m_dat[last_q];
        wbs_sel_o = m_sel[last_q];
        wbs_we_o  = wbm_we_i[last_q];
        wbs_cyc_o = sel_cyc;
        wbs_stb_o = sel_stb;
        wbs_cti_o = m_cti[last_q];
        wbs_bte_o = m_bte[last_q];
        wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
        wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i}};
        wbm_rty_o = grant_q & {NUM_MASTERS{wbs_rty_i}};
      end
      StAbort: wbm_err_o = grant_q;
      default: ;
    endcase
  end

  assign grant_o       = grant_q;
  assign timeout_o     = (state_q == StAbort);
  assign timeout_adr_o = tadr_q;

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Bench for wb_io_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a behavioural ownership/timeout model.
module tb_wb_io_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] m_adr [N];
  logic [31:0] m_dat [N];
  logic [3:0]  m_sel [N];
  logic [2:0]  m_cti [N];
  logic [1:0]  m_bte [N];
  logic [N-1:0] m_we, m_cyc, m_stb, stb_pref;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;

  logic [32*N-1:0] adr_f, dat_f;
  logic [4*N-1:0]  sel_f;
  logic [3*N-1:0]  cti_f;
  logic [2*N-1:0]  bte_f;
  always_comb begin
    adr_f = '0;
    dat_f = '0;
    sel_f = '0;
    cti_f = '0;
    bte_f = '0;
    for (int i = 0; i < N; i++) begin
      adr_f[32*i +: 32] = m_adr[i];
      dat_f[32*i +: 32] = m_dat[i];
      sel_f[4*i +: 4]   = m_sel[i];
      cti_f[3*i +: 3]   = m_cti[i];
      bte_f[2*i +: 2]   = m_bte[i];
    end
  end

  logic [32*N-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [31:0]     wbs_adr_o, wbs_dat_o, timeout_adr_o;
  logic [3:0]      wbs_sel_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o, timeout_o;

  wb_io_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr_f), .wbm_dat_i(dat_f), .wbm_sel_i(sel_f), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(cti_f), .wbm_bte_i(bte_f),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o), .timeout_adr_o(timeout_adr_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus, whether the owner was just aborted or is draining,
  // and how many consecutive cycles its strobe has gone unanswered.
  bit          busy, aborted, draining;
  int          owner, last, waited;
  logic [31:0] tadr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    logic [N-1:0] g, own, ack_e, err_e, rty_e;
    bit active;
    own    = busy ? (N'(1) << owner) : '0;
    g      = own;
    active = busy && !aborted && !draining;
    ack_e  = (active && s_ack) ? own : '0;
    err_e  = ((active && s_err) || aborted) ? own : '0;
    rty_e  = (active && s_rty) ? own : '0;
    check("grant", grant_o, g);
    check("timeout", timeout_o, aborted);
    check("timeout_adr", timeout_adr_o, tadr);
    check("dat_bcast", wbm_dat_o, {N{s_dat}});
    check("ack", wbm_ack_o, ack_e);
    check("err", wbm_err_o, err_e);
    check("rty", wbm_rty_o, rty_e);
    check("wbs_cyc", wbs_cyc_o, active ? m_cyc[owner] : 1'b0);
    check("wbs_stb", wbs_stb_o, active ? m_stb[owner] : 1'b0);
    if (active) begin
      check("wbs_adr", wbs_adr_o, m_adr[owner]);
      check("wbs_dat", wbs_dat_o, m_dat[owner]);
      check("wbs_ctl", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
            {m_sel[owner], m_we[owner], m_cti[owner], m_bte[owner]});
    end else if (!busy) begin
      check("wbs_idle_zero", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
            0);
    end
  endtask

  task automatic model_update();
    int c;
    if (!rst_n) begin
      busy = 0; aborted = 0; draining = 0; last = N - 1; waited = 0; tadr = '0;
    end else if (!busy) begin
      for (int k = 1; k <= N; k++) begin
        c = (last + k) % N;
        if (!busy && m_cyc[c]) begin
          busy = 1; owner = c; last = c; waited = 0;
        end
      end
    end else if (aborted) begin
      aborted = 0; draining = 1;
    end else if (draining) begin
      if (!m_cyc[owner]) begin busy = 0; draining = 0; end
    end else if (!m_cyc[owner]) begin
      busy = 0;
    end else if (m_stb[owner] && !(s_ack || s_err || s_rty)) begin
      if (waited == TO) begin
        aborted = 1; tadr = m_adr[owner]; waited = 0;
      end else begin
        waited++;
      end
    end else begin
      waited = 0;
    end
  endtask

  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = 4'hf; m_cti[i] = '0; m_bte[i] = '0;
    end
    m_we = '0; m_cyc = '0; m_stb = '0; stb_pref = '0;
    s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  int quiet;

  initial begin
    clear_masters();
    s_dat = 32'h1234_5678;
    rst_n = 0;
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();
    rst_n = 1;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_tadr", timeout_adr_o, 0);
    check("rst_cyc", wbs_cyc_o, 0);

    // Single master read with ack two cycles after stb.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h1000;
    step();
    #1;
    check("s1_grant", grant_o, 3'b001);
    check("s1_adr", wbs_adr_o, 32'h1000);
    step();
    step();
    s_ack = 1; s_dat = 32'hCAFE_0001;
    #1;
    check("s1_ack", wbm_ack_o, 3'b001);
    check("s1_rdata", wbm_dat_o[31:0], 32'hCAFE_0001);
    step();
    s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
    step();
    #1;
    check("s1_idle", grant_o, 0);
    step();

    // Simultaneous requests after reset, then round-robin.
    rst_n = 0;
    step();
    rst_n = 1;
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11; m_adr[0] = 32'h100; m_adr[1] = 32'h200;
    step();
    #1;
    check("s2_first", grant_o, 3'b001);
    s_ack = 1;
    step();
    s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
    step();
    #1;
    check("s2_gap", grant_o, 0);
    step();
    #1;
    check("s2_second", grant_o, 3'b010);
    s_ack = 1;
    #1;
    check("s2_ack1", wbm_ack_o, 3'b010);
    step();
    s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
    step();
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11;
    step();
    #1;
    check("s2_rr", grant_o, 3'b001);
    m_cyc = '0; m_stb = '0;
    step();
    step();

    // Four-beat burst from master 1 while master 0 waits.
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11; m_adr[1] = 32'h3000;
    step();
    for (int b = 0; b < 4; b++) begin
      logic [2:0] cti_e;
      cti_e = (b == 3) ? 3'b111 : 3'b010;
      m_cti[1] = cti_e; m_adr[1] = 32'h3000 + 32'(4 * b); s_ack = 1;
      #1;
      check("s3_grant", grant_o, 3'b010);
      check("s3_ack", wbm_ack_o, 3'b010);
      check("s3_cti", wbs_cti_o, cti_e);
      step();
    end
    s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
    step();
    step();
    m_cyc[0] = 0; m_stb[0] = 0;
    step();
    step();

    // Watchdog abort on a slave that never answers.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h2000;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s4_noerr", wbm_err_o, 0);
      check("s4_stb", wbs_stb_o, 1);
      step();
    end
    #1;
    check("s4_err", wbm_err_o, 3'b001);
    check("s4_timeout", timeout_o, 1);
    check("s4_stb_off", wbs_stb_o, 0);
    step();
    #1;
    check("s4_drain_cyc", wbs_cyc_o, 0);
    check("s4_tadr", timeout_adr_o, 32'h2000);
    check("s4_pulse", timeout_o, 0);
    step();
    step();
    m_cyc[0] = 0; m_stb[0] = 0;
    step();
    #1;
    check("s4_idle", grant_o, 0);
    step();

    // Response arriving exactly at expiry wins over the abort.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h2400;
    step();
    for (int i = 0; i < 4; i++) step();
    s_ack = 1;
    #1;
    check("s5_ack", wbm_ack_o, 3'b001);
    check("s5_noerr", wbm_err_o, 0);
    check("s5_notimeout", timeout_o, 0);
    step();
    s_ack = 0;
    #1;
    check("s5_still_grant", grant_o, 3'b001);
    check("s5_no_abort", timeout_o, 0);
    step();
    m_cyc[0] = 0; m_stb[0] = 0;
    step();
    step();

    // Reset during beat 2 of a burst.
    m_cyc[1:0] = 2'b11; m_stb[1:0] = 2'b11; m_cti[1] = 3'b010; m_adr[1] = 32'h5000;
    step();
    s_ack = 1;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    check("s6_grant", grant_o, 0);
    check("s6_wbs", {wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
                     wbs_cti_o, wbs_bte_o}, 0);
    check("s6_tadr", timeout_adr_o, 0);
    check("s6_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    step();
    #1;
    check("s6_first", grant_o, 3'b001);
    clear_masters();
    step();
    step();

    // Random traffic against the model.
    quiet = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) m_cyc[i] = ~m_cyc[i];
        if ($urandom_range(5) == 0) stb_pref[i] = ~stb_pref[i];
        m_stb[i] = stb_pref[i];
        m_adr[i] = $urandom;
        m_dat[i] = $urandom;
        m_sel[i] = 4'($urandom);
        m_cti[i] = 3'($urandom);
        m_bte[i] = 2'($urandom);
        m_we[i]  = 1'($urandom);
      end
      if (quiet == 0 && $urandom_range(31) == 0) quiet = $urandom_range(12);
      if (quiet > 0) begin
        quiet--;
        s_ack = 0; s_err = 0; s_rty = 0;
      end else begin
        s_ack = ($urandom_range(3) == 0);
        s_err = ($urandom_range(15) == 0);
        s_rty = ($urandom_range(15) == 0);
      end
      s_dat = $urandom;
      rst_n = ($urandom_range(199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_io_arbiter.md
# wb_io_arbiter

Round-robin Wishbone arbiter that shares the single IO-bus master port of the SoC interconnect between several bus masters (core data port, debug module, DMA). It sits directly in front of the interconnect's `wb_io_*` master port. It holds a grant for the whole of a master's `cyc` (single or burst), and it forwards the address and control signals of exactly one master. A watchdog aborts any transfer that a slave never terminates, so one stalled master cannot lock the IO bus.

## Interface

**Parameters**
- `NUM_MASTERS`, default 2: number of requesting masters, range 2..8.
- `TIMEOUT_CYCLES`, default 255: number of cycles `stb` may stay unanswered before abort. 0 disables the watchdog.
- `CNT_W`, default 8: watchdog counter width. Must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

**Ports** (master index i occupies slice i of each flattened vector)
- `wb_clk_i` in 1: clock.
- `wb_rst_n_i` in 1: reset, synchronous, active-low.
- `wbm_adr_i` in 32*N: master addresses.
- `wbm_dat_i` in 32*N: master write data.
- `wbm_sel_i` in 4*N: byte selects.
- `wbm_we_i` in N: write enables.
- `wbm_cyc_i` in N: cycle requests.
- `wbm_stb_i` in N: strobes.
- `wbm_cti_i` in 3*N: cycle type identifiers.
- `wbm_bte_i` in 2*N: burst type extensions.
- `wbm_dat_o` out 32*N: read data, broadcast to all masters.
- `wbm_ack_o` out N: acknowledges.
- `wbm_err_o` out N: errors.
- `wbm_rty_o` out N: retries.
- `wbs_adr_o` out 32: address to the interconnect.
- `wbs_dat_o` out 32: write data to the interconnect.
- `wbs_sel_o` out 4: byte selects to the interconnect.
- `wbs_we_o` out 1: write enable to the interconnect.
- `wbs_cyc_o` out 1: cycle to the interconnect.
- `wbs_stb_o` out 1: strobe to the interconnect.
- `wbs_cti_o` out 3: cycle type to the interconnect.
- `wbs_bte_o` out 2: burst type to the interconnect.
- `wbs_dat_i` in 32: read data from the interconnect.
- `wbs_ack_i` in 1: acknowledge from the interconnect.
- `wbs_err_i` in 1: error from the interconnect.
- `wbs_rty_i` in 1: retry from the interconnect.
- `grant_o` out N: one-hot current grant; all zero when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog aborts a transfer.
- `timeout_adr_o` out 32: address of the most recently aborted transfer.

## Operation

**States**
- IDLE: no grant. All `wbs_*` outputs are 0 and all `wbm_ack/err/rty_o` are 0.
  - Any `wbm_cyc_i` high → GRANT.
  - The winner is the first requester found scanning upward (modulo N) from `last+1`.
  - The `grant` and `last` registers load on that edge.
- GRANT: the granted master's adr/dat/sel/we/cyc/stb/cti/bte pass combinationally to `wbs_*`.
  - `wbs_ack/err/rty_i` route to the granted master only. All other masters see 0.
  - `wbm_dat_o` is `wbs_dat_i` replicated to every slice.
  - Granted `wbm_cyc_i` low → IDLE; the grant clears on that edge.
  - Watchdog expiry → ABORT.
- ABORT: lasts exactly one cycle.
  - `wbs_cyc_o` = `wbs_stb_o` = 0.
  - The granted master's `wbm_err_o` = 1 and its ack/rty = 0.
  - `timeout_o` = 1 and `timeout_adr_o` captures the granted master's address.
  - Next state is DRAIN.
- DRAIN: `wbs_cyc_o` and `wbs_stb_o` are forced to 0 and all master responses are 0. Granted `wbm_cyc_i` low → IDLE.

**Watchdog**
- The counter clears whenever the state is not GRANT, the granted `stb` is low, or any of `wbs_ack/err/rty_i` is high.
- Otherwise it increments by 1, saturating at `2**CNT_W-1`.
- Expiry occurs when the counter equals `TIMEOUT_CYCLES` while `stb` is high and no response is present. The state moves to ABORT on that edge.
- A response arriving in the same cycle as the expiry condition wins: it is forwarded and no abort occurs.
- `TIMEOUT_CYCLES` = 0: the counter stays at 0 and ABORT is unreachable.

**Rules**
- A master that drops `cyc` while an ack is pending loses the grant. Any late slave response is discarded: it is not routed to any master.
- Requests from non-granted masters are ignored until the state returns to IDLE. No master is ever starved; its maximum wait is N-1 complete cycles.
- `stb` high with `cyc` low on a master is treated as no request.

**Reset** (`wb_rst_n_i` low at an edge, including mid-transfer or mid-burst)
- State is IDLE and `grant_o` is 0.
- `last` is N-1, so master 0 has first priority after reset.
- The watchdog counter is 0, `timeout_o` is 0 and `timeout_adr_o` is 32'h0.
- All `wbs_*_o` are 0 and all `wbm_ack/err/rty_o` are 0.
- `wbm_dat_o` follows `wbs_dat_i`.

## Timing

- Arbitration latency is one cycle: a request at edge t reaches `wbs_cyc_o`/`wbs_stb_o` in the cycle after edge t+1.
- There is one IDLE cycle between consecutive grants; back-to-back grants are not allowed.
- Forwarding is combinational in GRANT, with zero added latency on requests and responses. Burst throughput equals slave throughput.
- `grant_o`, the state, the counter and `timeout_adr_o` are registers. `timeout_o` is decoded from the state.
- The abort err reaches the master exactly `TIMEOUT_CYCLES`+1 cycles after its `stb` was first forwarded without a response.

## Test plan

- **Single master read:** master 0 reads 0x1000 and the slave acks 2 cycles after `stb`. Required: `grant_o`=01 one cycle after `cyc`; `wbm_ack_o[0]` in the same cycle as `wbs_ack_i`; `wbm_dat_o[31:0]` equals the slave data; IDLE after `cyc` drops.
- **Simultaneous requests after reset:** masters 0 and 1 request together. Required: master 0 is granted first; master 1 is granted after master 0's `cyc` falls, with one IDLE cycle between. A second simultaneous request after that grants master 0 (round-robin).
- **Burst hold:** master 1 runs a 4-beat incrementing burst (cti 010 then 111) while master 0 requests. Required: the grant stays 10 for all 4 acks; master 0 sees no ack.
- **Watchdog abort:** `TIMEOUT_CYCLES`=4, master 0 accesses 0x2000 and the slave never acks. Required: `wbm_err_o[0]` and `timeout_o` pulse in the 5th cycle after `stb`; `wbs_stb_o` is 0 in that cycle; `timeout_adr_o`=0x2000; DRAIN until `cyc` drops.
- **Response at expiry:** the slave acks exactly at counter = `TIMEOUT_CYCLES`. Required: ack is forwarded; no err; `timeout_o` stays 0.
- **Reset mid-burst:** `wb_rst_n_i` is pulled low during beat 2. Required: the next cycle shows `grant_o`=0, all `wbs_*_o`=0 and `timeout_adr_o`=0; the first grant after release goes to master 0 when both masters request.
